nvme_sq_engine: RTL

Multi-queue NVMe submission-queue producer. It accepts 64 B submission queue entries (SQEs) tagged with a queue ID and writes each one into on-chip SQ memory through a single-beat AXI write master. It then rings that queue's SQ tail doorbell through an AXI-Lite write master to the NVMe controller. Per-queue tail and head pointers are kept here; head pointers are updated from SQHD values reported in completions.

---
 rtl/nvme_sq_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/nvme_sq_engine.sv
// Multi-queue NVMe submission-queue producer: writes one 64 B SQE per command into SQ memory
// over a single-beat AXI write, then rings that queue's tail doorbell over AXI-Lite.
module nvme_sq_engine #(
    parameter int          NUM_QUEUES    = 4,
    parameter int          QUEUE_DEPTH   = 16,
    parameter int          SQ_ADDR_WIDTH = 12,
    parameter int          SQ_DATA_WIDTH = 512,
    parameter int          NL_ADDR_WIDTH = 32,
    parameter int          NL_DATA_WIDTH = 32,
    parameter logic [31:0] DB_BASE       = 32'h1000,
    parameter int          DB_STRIDE     = 8,
    localparam int         QW            = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    localparam int         PW            = $clog2(QUEUE_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [QW-1:0]                cmd_qid,
    input  logic [SQ_DATA_WIDTH-1:0]     cmd_data,

    input  logic                         hd_valid,
    input  logic [QW-1:0]                hd_qid,
    input  logic [15:0]                  hd_sqhd,

    output logic [SQ_ADDR_WIDTH-1:0]     sq_awaddr,
    output logic [7:0]                   sq_awlen,
    output logic [2:0]                   sq_awsize,
    output logic [1:0]                   sq_awburst,
    output logic                         sq_awvalid,
    input  logic                         sq_awready,
    output logic [SQ_DATA_WIDTH-1:0]     sq_wdata,
    output logic [SQ_DATA_WIDTH/8-1:0]   sq_wstrb,
    output logic                         sq_wlast,
    output logic                         sq_wvalid,
    input  logic                         sq_wready,
    input  logic [1:0]                   sq_bresp,
    input  logic                         sq_bvalid,
    output logic                         sq_bready,

    output logic [NL_ADDR_WIDTH-1:0]     nl_awaddr,
    output logic                         nl_awvalid,
    input  logic                         nl_awready,
    output logic [NL_DATA_WIDTH-1:0]     nl_wdata,
    output logic [NL_DATA_WIDTH/8-1:0]   nl_wstrb,
    output logic                         nl_wvalid,
    input  logic                         nl_wready,
    input  logic [1:0]                   nl_bresp,
    input  logic                         nl_bvalid,
    output logic                         nl_bready,

    output logic [NUM_QUEUES-1:0]        sq_full,
    output logic [1:0]                   err
);

    localparam int QN = 2 ** QW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_REQ,
        S_SQ_RESP,
        S_DB_REQ,
        S_DB_RESP
    } state_t;

    state_t              r_state;
    logic [QW-1:0]       r_qid;
    logic [PW-1:0]       r_tail [QN];
    logic [PW-1:0]       r_head [QN];

    logic [QN-1:0]       w_full_ext;
    logic [QW+PW-1:0]    w_cmd_slot;
    logic [SQ_ADDR_WIDTH-1:0] w_cmd_addr;
    logic [PW-1:0]       w_tail_next;
    logic [NL_ADDR_WIDTH-1:0] w_db_addr;

    assign sq_awlen   = 8'd0;
    assign sq_awsize  = 3'b110;
    assign sq_awburst = 2'b01;
    assign sq_wlast   = 1'b1;
    assign sq_wstrb   = '1;
    assign nl_wstrb   = '1;

    // One slot stays empty so that tail==head always means "empty".
    always_comb begin
        w_full_ext = '0;
        for (int q = 0; q < QN; q++) begin
            w_full_ext[q] = (PW'(r_tail[q] + 1'b1) == r_head[q]);
        end
    end

    assign sq_full   = w_full_ext[NUM_QUEUES-1:0];
    assign cmd_ready = (r_state == S_IDLE) && !w_full_ext[cmd_qid];

    // Queue depth is a power of two, so {qid, tail} is qid*QUEUE_DEPTH + tail.
    assign w_cmd_slot  = {cmd_qid, r_tail[cmd_qid]};
    assign w_cmd_addr  = SQ_ADDR_WIDTH'({w_cmd_slot, 6'b000000});
    assign w_tail_next = r_tail[r_qid] + PW'(1);
    assign w_db_addr   = NL_ADDR_WIDTH'(DB_BASE)
                       + NL_ADDR_WIDTH'(r_qid) * NL_ADDR_WIDTH'(DB_STRIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_qid      <= '0;
            for (int q = 0; q < QN; q++) begin
                r_tail[q] <= '0;
            end
            sq_awaddr  <= '0;
            sq_awvalid <= 1'b0;
            sq_wdata   <= '0;
            sq_wvalid  <= 1'b0;
            sq_bready  <= 1'b0;
            nl_awaddr  <= '0;
            nl_awvalid <= 1'b0;
            nl_wdata   <= '0;
            nl_wvalid  <= 1'b0;
            nl_bready  <= 1'b0;
            err        <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_qid      <= cmd_qid;
                        sq_wdata   <= cmd_data;
                        sq_awaddr  <= w_cmd_addr;
                        sq_awvalid <= 1'b1;
                        sq_wvalid  <= 1'b1;
                        r_state    <= S_SQ_REQ;
                    end
                end

                // A channel whose valid is already low has finished its handshake.
                S_SQ_REQ: begin
                    if (sq_awready) begin
                        sq_awvalid <= 1'b0;
                    end
                    if (sq_wready) begin
                        sq_wvalid <= 1'b0;
                    end
                    if ((!sq_awvalid || sq_awready) && (!sq_wvalid || sq_wready)) begin
                        sq_bready <= 1'b1;
                        r_state   <= S_SQ_RESP;
                    end
                end

                S_SQ_RESP: begin
                    if (sq_bvalid) begin
                        r_tail[r_qid] <= w_tail_next;
                        if (sq_bresp != 2'b00) begin
                            err[0] <= 1'b1;
                        end
                        sq_bready  <= 1'b0;
                        nl_awaddr  <= w_db_addr;
                        nl_wdata   <= NL_DATA_WIDTH'(w_tail_next);
                        nl_awvalid <= 1'b1;
                        nl_wvalid  <= 1'b1;
                        r_state    <= S_DB_REQ;
                    end
                end

                S_DB_REQ: begin
                    if (nl_awready) begin
                        nl_awvalid <= 1'b0;
                    end
                    if (nl_wready) begin
                        nl_wvalid <= 1'b0;
                    end
                    if ((!nl_awvalid || nl_awready) && (!nl_wvalid || nl_wready)) begin
                        nl_bready <= 1'b1;
                        r_state   <= S_DB_RESP;
                    end
                end

                S_DB_RESP: begin
                    if (nl_bvalid) begin
                        if (nl_bresp != 2'b00) begin
                            err[1] <= 1'b1;
                        end
                        nl_bready <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Out-of-range SQHD values are dropped silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < QN; q++) begin
                r_head[q] <= '0;
            end
        end else if (hd_valid && (32'(hd_sqhd) < 32'(QUEUE_DEPTH))) begin
            r_head[hd_qid] <= hd_sqhd[PW-1:0];
        end
    end

endmodule
